// File: rtl/armleocpu_store_buffer_pkg.sv
// Shared types for the store buffer: AXI response codes, FSM states, entries.
// Entry keeps only the word address since stores are already bus-aligned.
package armleocpu_store_buffer_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    STORE_BUFFER_IDLE,
    STORE_BUFFER_ISSUE,
    STORE_BUFFER_RESP
  } sb_state_t;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } sb_entry_t;

endpackage

// File: rtl/armleocpu_store_buffer_mem.sv
// Store buffer entry array: one write port, combinational head read,
// per-entry valid bits and word addresses for the load hazard compare.
module armleocpu_store_buffer_mem
  import armleocpu_store_buffer_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [PW-1:0]          wr_ptr,
  input  sb_entry_t              wr_entry,
  input  logic                   pop,
  input  logic [PW-1:0]          rd_ptr,
  output sb_entry_t              head,
  output logic [DEPTH-1:0]       entry_valid,
  output logic [DEPTH-1:0][29:0] entry_addr
);

  sb_entry_t mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i]         <= '0;
        entry_valid[i] <= 1'b0;
      end
    end else begin
      if (wr_en) begin
        mem[wr_ptr]         <= wr_entry;
        entry_valid[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        entry_valid[rd_ptr] <= 1'b0;
      end
    end
  end

  assign head = mem[rd_ptr];

  always_comb begin
    entry_addr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_addr[i] = mem[i].addr;
    end
  end

endmodule

// File: rtl/armleocpu_store_buffer.sv
// In-order store FIFO drained as single-outstanding AXI4-Lite writes.
// Ports: in_* store request, axi_* AW/W/B master, check_addr/pending_hit, empty, err_*.
module armleocpu_store_buffer
  import armleocpu_store_buffer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  input  logic [3:0]  in_strb,
  output logic        axi_awvalid,
  input  logic        axi_awready,
  output logic [31:0] axi_awaddr,
  output logic        axi_wvalid,
  input  logic        axi_wready,
  output logic [31:0] axi_wdata,
  output logic [3:0]  axi_wstrb,
  input  logic        axi_bvalid,
  output logic        axi_bready,
  input  logic [1:0]  axi_bresp,
  input  logic [31:0] check_addr,
  output logic        pending_hit,
  output logic        empty,
  output logic        err_valid,
  output logic [31:0] err_addr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  sb_state_t     state, state_nxt;
  logic          aw_done, aw_done_nxt;
  logic          w_done, w_done_nxt;
  logic [CW-1:0] count;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;
  logic          aw_hs, w_hs, b_hs, bad_resp;
  sb_entry_t     wr_entry, head;
  logic [DEPTH-1:0]       entry_valid;
  logic [DEPTH-1:0][29:0] entry_addr;
  logic          unused_lsbs;

  assign unused_lsbs = ^{in_addr[1:0], check_addr[1:0]};

  assign in_ready = (count != FULL);
  assign empty    = (count == '0);
  assign push     = in_valid && in_ready;

  assign axi_awvalid = (state == STORE_BUFFER_ISSUE) && !aw_done;
  assign axi_wvalid  = (state == STORE_BUFFER_ISSUE) && !w_done;
  assign axi_bready  = (state == STORE_BUFFER_RESP);
  assign axi_awaddr  = {head.addr, 2'b00};
  assign axi_wdata   = head.data;
  assign axi_wstrb   = head.strb;

  assign aw_hs    = axi_awvalid && axi_awready;
  assign w_hs     = axi_wvalid && axi_wready;
  assign b_hs     = axi_bready && axi_bvalid;
  assign pop      = b_hs;
  assign bad_resp = b_hs && (axi_bresp != AXI_RESP_OKAY);

  assign wr_entry = '{addr: in_addr[31:2], data: in_data, strb: in_strb};

  armleocpu_store_buffer_mem #(
    .DEPTH(DEPTH)
  ) u_mem (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (push),
    .wr_ptr     (wr_ptr),
    .wr_entry   (wr_entry),
    .pop        (pop),
    .rd_ptr     (rd_ptr),
    .head       (head),
    .entry_valid(entry_valid),
    .entry_addr (entry_addr)
  );

  always_comb begin
    state_nxt   = state;
    aw_done_nxt = aw_done;
    w_done_nxt  = w_done;
    unique case (state)
      STORE_BUFFER_IDLE: begin
        if (count != '0) state_nxt = STORE_BUFFER_ISSUE;
      end
      STORE_BUFFER_ISSUE: begin
        aw_done_nxt = aw_done || aw_hs;
        w_done_nxt  = w_done || w_hs;
        if (aw_done_nxt && w_done_nxt) begin
          state_nxt   = STORE_BUFFER_RESP;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
        end
      end
      STORE_BUFFER_RESP: begin
        if (axi_bvalid) state_nxt = STORE_BUFFER_IDLE;
      end
      default: begin
        state_nxt = STORE_BUFFER_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= STORE_BUFFER_IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= state_nxt;
      aw_done <= aw_done_nxt;
      w_done  <= w_done_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Head is still present in the array when the failing response arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
    end else begin
      err_valid <= bad_resp;
      if (bad_resp) err_addr <= {head.addr, 2'b00};
    end
  end

  always_comb begin
    pending_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && (entry_addr[i] == check_addr[31:2]))
        pending_hit = 1'b1;
    end
  end

endmodule

// File: tb/tb_armleocpu_store_buffer.sv
// Self-checking bench for armleocpu_store_buffer with an AXI slave model
// and a scoreboard of expected writes compared against captured AW/W beats.
module tb_armleocpu_store_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_addr = '0;
  logic [31:0] in_data = '0;
  logic [3:0]  in_strb = '0;
  logic        axi_awvalid;
  logic        axi_awready;
  logic [31:0] axi_awaddr;
  logic        axi_wvalid;
  logic        axi_wready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_bvalid;
  logic        axi_bready;
  logic [1:0]  axi_bresp;
  logic [31:0] check_addr = '0;
  logic        pending_hit;
  logic        empty;
  logic        err_valid;
  logic [31:0] err_addr;

  typedef logic [67:0] wr_t;

  wr_t         exp_q[$];
  logic [31:0] got_aw[$];
  logic [35:0] got_w[$];
  logic [1:0]  resp_q[$];

  int checks = 0;
  int errors = 0;
  int aw_wait = 0;
  int w_wait = 0;
  bit aw_block = 1'b0;
  int aw_cnt = 0;
  int w_cnt = 0;
  int b_cnt = 0;
  int err_cnt = 0;

  armleocpu_store_buffer #(
    .DEPTH(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .in_strb    (in_strb),
    .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready),
    .axi_awaddr (axi_awaddr),
    .axi_wvalid (axi_wvalid),
    .axi_wready (axi_wready),
    .axi_wdata  (axi_wdata),
    .axi_wstrb  (axi_wstrb),
    .axi_bvalid (axi_bvalid),
    .axi_bready (axi_bready),
    .axi_bresp  (axi_bresp),
    .check_addr (check_addr),
    .pending_hit(pending_hit),
    .empty      (empty),
    .err_valid  (err_valid),
    .err_addr   (err_addr)
  );

  always #5 clk = ~clk;

  // Slave: drives readies at the falling edge, so a beat captured here
  // is handshaken on the following rising edge.
  initial begin
    axi_awready = 1'b0;
    axi_wready  = 1'b0;
    axi_bvalid  = 1'b0;
    axi_bresp   = 2'b00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        axi_awready = 1'b0;
        axi_wready  = 1'b0;
        axi_bvalid  = 1'b0;
        aw_cnt = 0;
        w_cnt  = 0;
      end else begin
        if (axi_awvalid && !aw_block && aw_cnt >= aw_wait) begin
          axi_awready = 1'b1;
          got_aw.push_back(axi_awaddr);
          aw_cnt = 0;
        end else begin
          axi_awready = 1'b0;
          if (axi_awvalid) aw_cnt++;
        end
        if (axi_wvalid && w_cnt >= w_wait) begin
          axi_wready = 1'b1;
          got_w.push_back({axi_wdata, axi_wstrb});
          w_cnt = 0;
        end else begin
          axi_wready = 1'b0;
          if (axi_wvalid) w_cnt++;
        end
        if (axi_bready) begin
          axi_bvalid = 1'b1;
          axi_bresp = (resp_q.size() != 0) ? resp_q.pop_front() : 2'b00;
          b_cnt++;
        end else begin
          axi_bvalid = 1'b0;
          axi_bresp  = 2'b00;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (err_valid) err_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic push(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s);
    int n = 0;
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    in_strb  = s;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout in_ready %b required 1", in_ready);
    end else begin
      @(negedge clk);
      exp_q.push_back({a[31:2], 2'b00, d, s});
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    int n = 0;
    while (!empty && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = empty;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({axi_awvalid, axi_wvalid, axi_bready, err_valid} !== 4'b0) begin
      errors++;
      $display("FAIL reset_valids got %b required 0000",
               {axi_awvalid, axi_wvalid, axi_bready, err_valid});
    end
    checks++;
    if (empty !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_empty got %b%b required 11", empty, in_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (err_addr !== 32'h0 || pending_hit !== 1'b0) begin
      errors++;
      $display("FAIL reset_err_addr got %h/%b required 0/0",
               err_addr, pending_hit);
    end
  endtask

  task automatic test_single;
    bit ok;
    wr_t e, g;
    int eb = err_cnt;
    push(32'h1000_0006, 32'h00AB_0000, 4'b0100);
    checks++;
    if (empty !== 1'b0) begin
      errors++;
      $display("FAIL single_not_empty got %b required 0", empty);
    end
    @(negedge clk);
    checks++;
    if (!(axi_awvalid === 1'b1 && axi_wvalid === 1'b1)) begin
      errors++;
      $display("FAIL single_valids got %b%b required 11",
               axi_awvalid, axi_wvalid);
    end
    checks++;
    if (axi_awaddr !== 32'h1000_0004 || axi_wdata !== 32'h00AB_0000 ||
        axi_wstrb !== 4'b0100) begin
      errors++;
      $display("FAIL single_beat got %h %h %b required 10000004 00ab0000 0100",
               axi_awaddr, axi_wdata, axi_wstrb);
    end
    @(negedge clk);
    checks++;
    if (axi_bready !== 1'b1) begin
      errors++;
      $display("FAIL single_bready got %b required 1", axi_bready);
    end
    @(negedge clk);
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL single_empty got %b required 1", empty);
    end
    wait_drain(ok);
    repeat (2) @(negedge clk);
    checks++;
    if (err_cnt != eb) begin
      errors++;
      $display("FAIL single_no_err got %0d pulses required 0", err_cnt - eb);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = '0;
      if (got_aw.size() != 0 && got_w.size() != 0)
        g = {got_aw.pop_front(), got_w.pop_front()};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL single_sb got %h required %h", g, e);
      end
    end
  endtask

  task automatic test_full;
    bit ok;
    wr_t e, g;
    int n = 0;
    int bb;
    aw_block = 1'b1;
    push(32'h4000_0000, 32'hA000_0001, 4'b1111);
    push(32'h4000_0104, 32'hB000_0002, 4'b0011);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready got %b required 0", in_ready);
    end
    in_valid = 1'b1;
    in_addr  = 32'h4000_0208;
    in_data  = 32'hC000_0003;
    in_strb  = 4'b1100;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || got_aw.size() != 0) begin
      errors++;
      $display("FAIL full_hold got ready %b aw %0d required 0 0",
               in_ready, got_aw.size());
    end
    bb = b_cnt;
    aw_block = 1'b0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1 || b_cnt != bb + 1) begin
      errors++;
      $display("FAIL full_third got ready %b b %0d required 1 1",
               in_ready, b_cnt - bb);
    end
    @(negedge clk);
    exp_q.push_back({in_addr[31:2], 2'b00, in_data, in_strb});
    in_valid = 1'b0;
    wait_drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL full_drain empty %b required 1", empty);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = '0;
      if (got_aw.size() != 0 && got_w.size() != 0)
        g = {got_aw.pop_front(), got_w.pop_front()};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL full_order got %h required %h", g, e);
      end
    end
  endtask

  task automatic test_split;
    bit ok;
    wr_t e, g;
    aw_wait = 3;
    push(32'h5000_0010, 32'h1234_5678, 4'b1010);
    @(negedge clk);
    checks++;
    if ({axi_awvalid, axi_wvalid} !== 2'b11) begin
      errors++;
      $display("FAIL split_start got %b required 11",
               {axi_awvalid, axi_wvalid});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({axi_awvalid, axi_wvalid, axi_bready} !== 3'b100) begin
        errors++;
        $display("FAIL split_wait%0d got %b required 100", i,
                 {axi_awvalid, axi_wvalid, axi_bready});
      end
    end
    @(negedge clk);
    checks++;
    if ({axi_awvalid, axi_wvalid, axi_bready} !== 3'b001) begin
      errors++;
      $display("FAIL split_resp got %b required 001",
               {axi_awvalid, axi_wvalid, axi_bready});
    end
    aw_wait = 0;
    wait_drain(ok);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = '0;
      if (got_aw.size() != 0 && got_w.size() != 0)
        g = {got_aw.pop_front(), got_w.pop_front()};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL split_sb got %h required %h", g, e);
      end
    end
  endtask

  task automatic test_error;
    bit ok;
    wr_t e, g;
    int n = 0;
    int eb = err_cnt;
    resp_q.push_back(2'b10);
    push(32'h2000_0010, 32'h1111_1111, 4'b1111);
    push(32'h2000_0020, 32'h2222_2222, 4'b0011);
    while (!err_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (err_valid !== 1'b1 || err_addr !== 32'h2000_0010) begin
      errors++;
      $display("FAIL err_pulse got %b %h required 1 20000010",
               err_valid, err_addr);
    end
    @(negedge clk);
    checks++;
    if (err_valid !== 1'b0) begin
      errors++;
      $display("FAIL err_one_cycle got %b required 0", err_valid);
    end
    wait_drain(ok);
    repeat (2) @(negedge clk);
    checks++;
    if (err_cnt != eb + 1 || err_addr !== 32'h2000_0010) begin
      errors++;
      $display("FAIL err_count got %0d %h required 1 20000010",
               err_cnt - eb, err_addr);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = '0;
      if (got_aw.size() != 0 && got_w.size() != 0)
        g = {got_aw.pop_front(), got_w.pop_front()};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL err_sb got %h required %h", g, e);
      end
    end
  endtask

  task automatic test_hazard;
    bit ok;
    aw_block = 1'b1;
    in_valid   = 1'b1;
    in_addr    = 32'h3000_0008;
    in_data    = 32'hDEAD_BEEF;
    in_strb    = 4'b1111;
    check_addr = 32'h3000_000B;
    #1;
    checks++;
    if (pending_hit !== 1'b0) begin
      errors++;
      $display("FAIL hazard_same_cycle got %b required 0", pending_hit);
    end
    @(negedge clk);
    in_valid = 1'b0;
    exp_q.push_back({32'h3000_0008, 32'hDEAD_BEEF, 4'b1111});
    checks++;
    if (pending_hit !== 1'b1) begin
      errors++;
      $display("FAIL hazard_hit got %b required 1", pending_hit);
    end
    check_addr = 32'h3000_000C;
    #1;
    checks++;
    if (pending_hit !== 1'b0) begin
      errors++;
      $display("FAIL hazard_miss got %b required 0", pending_hit);
    end
    check_addr = 32'h3000_000B;
    @(negedge clk);
    checks++;
    if (pending_hit !== 1'b1) begin
      errors++;
      $display("FAIL hazard_inflight got %b required 1", pending_hit);
    end
    aw_block = 1'b0;
    wait_drain(ok);
    checks++;
    if (pending_hit !== 1'b0 || !ok) begin
      errors++;
      $display("FAIL hazard_clear got %b required 0", pending_hit);
    end
    exp_q.delete();
    got_aw.delete();
    got_w.delete();
  endtask

  task automatic test_reset_mid;
    int seen = 0;
    aw_block = 1'b1;
    push(32'h6000_0000, 32'h6666_0000, 4'b1111);
    push(32'h6000_0004, 32'h7777_0000, 4'b1111);
    checks++;
    if (axi_awvalid !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_issue got %b required 1", axi_awvalid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({axi_awvalid, axi_wvalid, axi_bready} !== 3'b000) begin
      errors++;
      $display("FAIL rst_mid_valids got %b required 000",
               {axi_awvalid, axi_wvalid, axi_bready});
    end
    checks++;
    if (empty !== 1'b1 || in_ready !== 1'b1 || pending_hit !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_empty got %b%b%b required 110",
               empty, in_ready, pending_hit);
    end
    repeat (2) @(negedge clk);
    exp_q.delete();
    got_aw.delete();
    got_w.delete();
    aw_block = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (axi_awvalid || axi_wvalid) seen++;
    end
    checks++;
    if (seen != 0 || got_aw.size() != 0 || got_w.size() != 0) begin
      errors++;
      $display("FAIL rst_mid_quiet got %0d %0d %0d required 0 0 0",
               seen, got_aw.size(), got_w.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_split();
    test_error();
    test_hazard();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
